// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the data-SRAM port between the core load/store stage and a
//   secondary bus master (debug/DMA). The core always wins because its
//   pipeline cannot stall. The secondary master is served in cycles where
//   the core leaves memory idle.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   core_rd/wr/addr/wr_dat, core_rd_dat   core data-memory side
//   s_req/we/size/addr/wdata, s_gnt       secondary request/grant
//   s_rvalid, s_rdata                     secondary completion pulse + data
//   s_starve                              secondary blocked too long (status)
//   mem_rd/wr/addr/wr_dat, mem_rd_dat     SRAM side (async read, sync write)
module dmem_arbiter #(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            core_rd,
    input  logic            core_wr,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wr_dat,
    output logic [XLEN-1:0] core_rd_dat,
    input  logic            s_req,
    input  logic            s_we,
    input  logic [1:0]      s_size,
    input  logic [XLEN-1:0] s_addr,
    input  logic [XLEN-1:0] s_wdata,
    output logic            s_gnt,
    output logic            s_rvalid,
    output logic [XLEN-1:0] s_rdata,
    output logic            s_starve,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wr_dat,
    input  logic [XLEN-1:0] mem_rd_dat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } state_t;

    // One extra bit so a limit equal to the counter's maximum still compares.
    localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(STARVE_LIMIT);

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz,
                                                  input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (sz)
            2'b00:   r = {{(XLEN-8){1'b0}},  d[7:0]};
            2'b01:   r = {{(XLEN-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [XLEN-1:0]   rdata_q;

    logic              core_act;
    logic              latch_en;   // accept a new secondary request
    logic              access_en;  // secondary access owns memory this cycle
    logic              stall_en;   // secondary blocked by the core

    assign core_act    = core_rd | core_wr;
    assign core_rd_dat = mem_rd_dat;
    assign s_rdata     = rdata_q;
    assign s_starve    = (state_q == PEND) && ({1'b0, wait_cnt} >= LIMIT);

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        s_gnt     = 1'b0;
        s_rvalid  = 1'b0;
        latch_en  = 1'b0;
        access_en = 1'b0;
        stall_en  = 1'b0;
        case (state_q)
            IDLE: begin
                s_gnt = 1'b1;
                if (s_req) begin
                    latch_en = 1'b1;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (!core_act) begin
                    access_en = 1'b1;
                    state_d   = RESP;
                end else begin
                    stall_en = 1'b1;
                end
            end
            RESP: begin
                s_rvalid = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latched request, wait counter and response data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
        end else begin
            if (latch_en) begin
                we_q    <= s_we;
                size_q  <= s_size;
                addr_q  <= s_addr;
                wdata_q <= size_mask(s_size, s_wdata);
            end
            if (access_en) begin
                rdata_q  <= we_q ? '0 : size_mask(size_q, mem_rd_dat);
                wait_cnt <= '0;
            end else if (stall_en && wait_cnt != {CNT_W{1'b1}}) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Memory port mux: core first, then a pending secondary access
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wr_dat = '0;
        if (core_act) begin
            mem_rd     = core_rd;
            mem_wr     = core_wr;
            mem_addr   = core_addr;
            mem_wr_dat = core_wr_dat;
        end else if (state_q == PEND) begin
            mem_rd     = ~we_q;
            mem_wr     = we_q;
            mem_addr   = addr_q;
            mem_wr_dat = wdata_q;
        end
    end

endmodule
